// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch stage of the RISC-V core. It owns the fetch PC and drives the
// synchronous-read instruction memory. Each returned word is buffered with
// its PC in a small FIFO. The head entry goes to the decoder over a
// valid/ready handshake. A redirect (branch/jump) loads a new PC and throws
// away every buffered or in-flight word.
//
// Parameters
//   RESET_PC      PC loaded on reset (bits [1:0] forced to 0)
//   DEPTH         FIFO entries; 2 is the minimum for one instruction per cycle
//
// Ports
//   CLK           clock, all state changes on the rising edge
//   RST           synchronous active-high reset, overrides every other input
//   address_IMEM  IMEM word address, fetch_pc[11:2]
//   data_IMEM     IMEM read data, valid one cycle after its address
//   redirect_i    load redirect_pc_i as the new PC and flush
//   redirect_pc_i redirect target, low two bits ignored
//   ready_i       decoder accepts the head entry this cycle
//   valid_o       head entry valid (FIFO not empty)
//   instr_o       head instruction (0 when not valid)
//   pc_o          PC of the head instruction (0 when not valid)
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        CLK,
  input  logic        RST,
  output logic [9:0]  address_IMEM,
  input  logic [31:0] data_IMEM,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;

  localparam logic [PTR_W-1:0] LAST_PTR         = PTR_W'(DEPTH - 1);
  localparam logic [OCC_W-1:0] DEPTH_OCC        = OCC_W'(DEPTH);
  localparam logic [31:0]      RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  logic [31:0]      r_fetchPc;
  logic             r_inflight;
  logic [31:0]      r_inflightPc;
  logic             r_squash;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] r_rdPtr;
  logic [PTR_W-1:0] r_wrPtr;
  logic [31:0]      r_fifoPc    [DEPTH];
  logic [31:0]      r_fifoInstr [DEPTH];

  logic             w_pop;
  logic             w_push;
  logic             w_issue;
  logic [OCC_W-1:0] w_occupancy;
  logic [31:0]      w_redirectPc;
  logic [PTR_W-1:0] w_rdPtrNext;
  logic [PTR_W-1:0] w_wrPtrNext;

  assign address_IMEM = r_fetchPc[11:2];

  // Head outputs come straight from the FIFO storage, so they stay stable
  // while the decoder stalls. They are forced to zero while the FIFO is empty.
  assign valid_o = (r_count != '0);
  assign pc_o    = valid_o ? r_fifoPc[r_rdPtr]    : 32'h0;
  assign instr_o = valid_o ? r_fifoInstr[r_rdPtr] : 32'h0;

  assign w_redirectPc = redirect_pc_i & 32'hFFFF_FFFC;

  // A new fetch is issued only if every word already owed to the FIFO
  // (buffered + in flight - leaving now) still leaves room for it. This
  // keeps the FIFO from overflowing, so no returning word is ever dropped.
  always_comb begin
    w_pop       = valid_o & ready_i;
    w_push      = r_inflight & ~r_squash & ~redirect_i;
    w_occupancy = {1'b0, r_count} + OCC_W'(r_inflight) - OCC_W'(w_pop);
    w_issue     = ~redirect_i & (w_occupancy < DEPTH_OCC);
    w_rdPtrNext = (r_rdPtr == LAST_PTR) ? '0 : r_rdPtr + 1'b1;
    w_wrPtrNext = (r_wrPtr == LAST_PTR) ? '0 : r_wrPtr + 1'b1;
  end

  // PC and in-flight tracking. A redirect turns any outstanding fetch into
  // a squashed one, so its returning word is discarded instead of pushed.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_fetchPc    <= RESET_PC_ALIGNED;
      r_inflight   <= 1'b0;
      r_inflightPc <= 32'h0;
      r_squash     <= 1'b0;
    end else if (redirect_i) begin
      r_fetchPc  <= w_redirectPc;
      r_inflight <= 1'b0;
      r_squash   <= r_inflight;
    end else begin
      r_squash <= 1'b0;
      if (w_issue) begin
        r_inflight   <= 1'b1;
        r_inflightPc <= r_fetchPc;
        r_fetchPc    <= r_fetchPc + 32'd4;
      end else begin
        r_inflight <= 1'b0;
      end
    end
  end

  // FIFO bookkeeping. A redirect empties the buffer. A push and a pop in
  // the same cycle leave the count unchanged.
  always_ff @(posedge CLK) begin
    if (RST || redirect_i) begin
      r_count <= '0;
      r_rdPtr <= '0;
      r_wrPtr <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= w_wrPtrNext;
      end
      if (w_pop) begin
        r_rdPtr <= w_rdPtrNext;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage needs no reset. Entries are only observed once the count
  // says they were written.
  always_ff @(posedge CLK) begin
    if (!RST && w_push) begin
      r_fifoPc[r_wrPtr]    <= r_inflightPc;
      r_fifoInstr[r_wrPtr] <= data_IMEM;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Self-checking bench for instr_fetch_unit. A behavioural IMEM returns
// word*3 one cycle after the address. The reference model treats the
// decoder side as a PC stream:
//   - every accepted instruction must carry the next expected PC and IMEM
//     contents;
//   - the expected PC restarts at the reset PC or at the redirect target;
//   - a stalled head must not change;
//   - valid_o must never be missing for more than two cycles after a
//     reset release or a redirect.
// Directed steps cover the latency and boundary cases. A random phase
// follows them.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        CLK;
  logic        RST;
  logic [9:0]  address_IMEM;
  logic [31:0] data_IMEM;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        ready_i;
  logic        valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;

  int checks   = 0;
  int failures = 0;

  logic [31:0] expPc;
  logic        heldValid;
  logic [31:0] heldPc;
  logic [31:0] heldInstr;
  int          invalidRun;

  instr_fetch_unit #(
    .RESET_PC (RESET_PC),
    .DEPTH    (2)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .address_IMEM  (address_IMEM),
    .data_IMEM     (data_IMEM),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .ready_i       (ready_i),
    .valid_o       (valid_o),
    .instr_o       (instr_o),
    .pc_o          (pc_o)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] imemWord(input logic [9:0] wordAddr);
    return {22'b0, wordAddr} * 32'd3;
  endfunction

  // Synchronous-read instruction memory
  always @(posedge CLK) data_IMEM <= imemWord(address_IMEM);

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive one cycle's inputs, run the stream model against the outputs
  // visible this cycle, then advance to just after the next rising edge.
  task automatic applyStimulus(input logic rst, input logic redir,
                               input logic [31:0] rpc, input logic rdy);
    RST           = rst;
    redirect_i    = redir;
    redirect_pc_i = rpc;
    ready_i       = rdy;
    if (rst) begin
      expPc      = RESET_PC;
      heldValid  = 1'b0;
      invalidRun = 0;
    end else begin
      if (heldValid) begin
        checkOutput("holdValid", {31'b0, valid_o}, 32'd1);
        checkOutput("holdPc", pc_o, heldPc);
        checkOutput("holdInstr", instr_o, heldInstr);
      end
      invalidRun = (valid_o === 1'b1) ? 0 : invalidRun + 1;
      checkOutput("liveness", {31'b0, invalidRun <= 2}, 32'd1);
      if (valid_o === 1'b1 && rdy) begin
        checkOutput("streamPc", pc_o, expPc);
        checkOutput("streamInstr", instr_o, imemWord(expPc[11:2]));
        expPc = expPc + 32'd4;
      end
      heldValid = (valid_o === 1'b1) && !rdy && !redir;
      heldPc    = pc_o;
      heldInstr = instr_o;
      if (redir) begin
        expPc      = rpc & 32'hFFFF_FFFC;
        invalidRun = 0;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
  endtask

  initial begin
    RST           = 1'b1;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    ready_i       = 1'b0;
    expPc         = RESET_PC;
    heldValid     = 1'b0;
    heldPc        = 32'h0;
    heldInstr     = 32'h0;
    invalidRun    = 0;

    // Reset state and streaming with ready held high
    $display("[TB] reset and streaming");
    doReset();
    checkOutput("rstValid", {31'b0, valid_o}, 32'd0);
    checkOutput("rstPc", pc_o, 32'h0);
    checkOutput("rstInstr", instr_o, 32'h0);
    checkOutput("rstAddr", {22'b0, address_IMEM}, 32'h0);
    for (int c = 0; c < 2; c++) begin
      checkOutput("earlyValid", {31'b0, valid_o}, 32'd0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    end
    for (int i = 0; i < 4; i++) begin
      checkOutput("t1Valid", {31'b0, valid_o}, 32'd1);
      checkOutput("t1Pc", pc_o, 32'(4 * i));
      checkOutput("t1Instr", instr_o, 32'(3 * i));
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    end

    // Decoder stall right after the first valid
    $display("[TB] stall and resume");
    doReset();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    for (int c = 0; c < 5; c++) begin
      checkOutput("t2Valid", {31'b0, valid_o}, 32'd1);
      checkOutput("t2Pc", pc_o, 32'h0);
      checkOutput("t2Addr", {22'b0, address_IMEM}, 32'd2);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      checkOutput("t2ResumeValid", {31'b0, valid_o}, 32'd1);
      checkOutput("t2ResumePc", pc_o, 32'(4 * i));
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    end

    // Redirect while the FIFO is full
    $display("[TB] redirect from full");
    for (int c = 0; c < 3; c++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("t3FullValid", {31'b0, valid_o}, 32'd1);
    applyStimulus(1'b0, 1'b1, 32'h0000_0100, 1'b0);
    checkOutput("t3Gap1", {31'b0, valid_o}, 32'd0);
    checkOutput("t3Addr", {22'b0, address_IMEM}, 32'h040);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("t3Gap2", {31'b0, valid_o}, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("t3Valid", {31'b0, valid_o}, 32'd1);
    checkOutput("t3Pc", pc_o, 32'h0000_0100);
    checkOutput("t3Instr", instr_o, 32'h0000_00C0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

    // Misaligned redirect target while a handshake completes
    $display("[TB] misaligned redirect");
    applyStimulus(1'b0, 1'b1, 32'h0000_0103, 1'b1);
    checkOutput("t4Addr", {22'b0, address_IMEM}, 32'h040);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("t4Pc", pc_o, 32'h0000_0100);

    // Back-to-back redirects: the second one wins
    applyStimulus(1'b0, 1'b1, 32'h0000_0200, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h0000_0300, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("b2bPc", pc_o, 32'h0000_0300);
    for (int c = 0; c < 4; c++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

    // Reset in mid-stream; a redirect in the same cycle must be ignored
    $display("[TB] reset mid-stream");
    applyStimulus(1'b1, 1'b1, 32'h0000_0500, 1'b1);
    checkOutput("t5Valid", {31'b0, valid_o}, 32'd0);
    checkOutput("t5Addr", {22'b0, address_IMEM}, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("t5RestartPc", pc_o, RESET_PC);

    // Word address wrap at 4 KiB
    $display("[TB] address wrap");
    applyStimulus(1'b0, 1'b1, 32'h0000_0FFC, 1'b1);
    checkOutput("t6Addr0", {22'b0, address_IMEM}, 32'h3FF);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("t6Addr1", {22'b0, address_IMEM}, 32'h000);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("t6Pc0", pc_o, 32'h0000_0FFC);
    checkOutput("t6Instr0", instr_o, 32'h0000_0BFD);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("t6Pc1", pc_o, 32'h0000_1000);
    checkOutput("t6Instr1", instr_o, 32'h0000_0000);

    // Full 32-bit PC wrap
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("wrapPc0", pc_o, 32'hFFFF_FFFC);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("wrapPc1", pc_o, 32'h0000_0000);

    // Random ready and redirects, checked only by the stream model
    $display("[TB] random phase");
    for (int c = 0; c < 500; c++) begin
      applyStimulus(1'b0, ($urandom_range(0, 19) == 0), $urandom,
                    ($urandom_range(0, 9) < 7));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
